// File: rtl/chip8_mem_arbiter.sv
// Arbiter for the shared single-port CHIP-8 RAM: loader priority, CPU/GPU round-robin,
// per-master lock for multi-byte bursts, and a registered one-cycle read-valid strobe.
module chip8_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              gpu_req,
  input  logic              gpu_we,
  input  logic              gpu_lock,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wdata,
  output logic              gpu_gnt,
  output logic              gpu_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_owner,
  output logic              dbg_rr
);

  // Handshake: a master raises x_req with x_we/x_addr/x_wdata/x_lock stable and holds them
  // until x_gnt; the access commits at the rising edge where x_gnt is high. A granted read
  // is answered by x_rvalid (with rdata) for exactly the following cycle.

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_GPU  = 2'd3
  } owner_t;

  owner_t            owner_q, owner_d;
  owner_t            win;
  logic              rr_q, rr_d;
  logic [2:0]        rd_pend_q, rd_pend_d;  // bit 0 = ld, 1 = cpu, 2 = gpu
  logic              owner_req;
  logic              win_lock;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= OWN_NONE;
      rr_q      <= 1'b0;
      rd_pend_q <= 3'b000;
    end else begin
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Winner selection; nothing is granted while reset is asserted.
  always_comb begin
    win       = OWN_NONE;
    owner_req = 1'b0;
    case (owner_q)
      OWN_LD:  owner_req = ld_req;
      OWN_CPU: owner_req = cpu_req;
      OWN_GPU: owner_req = gpu_req;
      default: owner_req = 1'b0;
    endcase
    if (reset) begin
      if (owner_req)                win = owner_q;
      else if (ld_req)              win = OWN_LD;
      else if (cpu_req && gpu_req)  win = rr_q ? OWN_GPU : OWN_CPU;
      else if (cpu_req)             win = OWN_CPU;
      else if (gpu_req)             win = OWN_GPU;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    win_lock  = 1'b0;
    ld_gnt    = 1'b0;
    cpu_gnt   = 1'b0;
    gpu_gnt   = 1'b0;
    owner_d   = owner_req ? owner_q : OWN_NONE;
    rr_d      = rr_q;
    rd_pend_d = 3'b000;
    case (win)
      OWN_LD: begin
        ld_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_we    = ld_we;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
        win_lock  = ld_lock;
        rd_pend_d = ld_we ? 3'b000 : 3'b001;
      end
      OWN_CPU: begin
        cpu_gnt   = 1'b1;
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        win_lock  = cpu_lock;
        rr_d      = 1'b1;
        rd_pend_d = cpu_we ? 3'b000 : 3'b010;
      end
      OWN_GPU: begin
        gpu_gnt   = 1'b1;
        mem_en    = 1'b1;
        mem_we    = gpu_we;
        mem_addr  = gpu_addr;
        mem_wdata = gpu_wdata;
        win_lock  = gpu_lock;
        rr_d      = 1'b0;
        rd_pend_d = gpu_we ? 3'b000 : 3'b100;
      end
      default: ;
    endcase
    if (win != OWN_NONE) owner_d = win_lock ? win : OWN_NONE;
  end

  assign ld_rvalid  = rd_pend_q[0];
  assign cpu_rvalid = rd_pend_q[1];
  assign gpu_rvalid = rd_pend_q[2];
  assign rdata      = mem_rdata;
  assign dbg_owner  = owner_q;
  assign dbg_rr     = rr_q;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter with a behavioural 4 KiB synchronous RAM behind it.
module tb_chip8_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req, ld_we, ld_lock, cpu_req, cpu_we, cpu_lock, gpu_req, gpu_we, gpu_lock;
  logic [11:0] ld_addr, cpu_addr, gpu_addr;
  logic [7:0]  ld_wdata, cpu_wdata, gpu_wdata;
  logic        ld_gnt, cpu_gnt, gpu_gnt, ld_rvalid, cpu_rvalid, gpu_rvalid;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [1:0]  dbg_owner;
  logic        dbg_rr;
  logic [7:0]  ram [0:4095];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_lock(gpu_lock), .gpu_addr(gpu_addr),
    .gpu_wdata(gpu_wdata), .gpu_gnt(gpu_gnt), .gpu_rvalid(gpu_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_owner(dbg_owner), .dbg_rr(dbg_rr)
  );

  // Synchronous single-port RAM model.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic set_idle();
    ld_req = 0; ld_we = 0; ld_lock = 0; ld_addr = '0; ld_wdata = '0;
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0;
    gpu_req = 0; gpu_we = 0; gpu_lock = 0; gpu_addr = '0; gpu_wdata = '0;
  endtask

  // Leaves the bench just after a falling edge with reset released and all masters idle.
  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    ld_req = 1; ld_addr = 12'h111; cpu_req = 1; cpu_addr = 12'h200;
    gpu_req = 1; gpu_addr = 12'h050; gpu_we = 1; gpu_wdata = 8'h5A;
    @(negedge clk); #1;
    n_total++;
    if ({ld_gnt, cpu_gnt, gpu_gnt} !== 3'b000) $display("FAIL rst_gnt got=%b exp=000", {ld_gnt, cpu_gnt, gpu_gnt});
    else n_pass++;
    n_total++;
    if ({ld_rvalid, cpu_rvalid, gpu_rvalid} !== 3'b000) $display("FAIL rst_rvalid got=%b exp=000", {ld_rvalid, cpu_rvalid, gpu_rvalid});
    else n_pass++;
    n_total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 22'h0) $display("FAIL rst_mem got=%h exp=0", {mem_en, mem_we, mem_addr, mem_wdata});
    else n_pass++;
    n_total++;
    if ({dbg_owner, dbg_rr} !== 3'b000) $display("FAIL rst_state got=%b exp=000", {dbg_owner, dbg_rr});
    else n_pass++;
    @(negedge clk);
    ld_req = 0; gpu_we = 0;
    reset = 1'b1;
    #1;
    n_total++;
    if ({cpu_gnt, gpu_gnt} !== 2'b10 || mem_addr !== 12'h200) $display("FAIL rst_first_cpu got=%b/%h exp=10/200", {cpu_gnt, gpu_gnt}, mem_addr);
    else n_pass++;
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic exp_cpu;
    do_reset();
    cpu_req = 1; cpu_addr = 12'h200; gpu_req = 1; gpu_addr = 12'h050;
    for (int k = 0; k < 4; k++) begin
      exp_cpu = (k % 2 == 0);
      #1;
      n_total++;
      if ({cpu_gnt, gpu_gnt} !== {exp_cpu, !exp_cpu} || mem_addr !== (exp_cpu ? 12'h200 : 12'h050))
        $display("FAIL rr_gnt[%0d] got=%b/%h exp=%b", k, {cpu_gnt, gpu_gnt}, mem_addr, {exp_cpu, !exp_cpu});
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if ({cpu_rvalid, gpu_rvalid} !== {exp_cpu, !exp_cpu} || rdata !== (exp_cpu ? 8'h11 : 8'h22))
        $display("FAIL rr_rvalid[%0d] got=%b/%h exp=%b/%h", k, {cpu_rvalid, gpu_rvalid}, rdata,
                 {exp_cpu, !exp_cpu}, exp_cpu ? 8'h11 : 8'h22);
      else n_pass++;
      @(negedge clk);
    end
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_loader_priority();
    do_reset();
    ld_req = 1; ld_we = 1; ld_addr = 12'h200; ld_wdata = 8'hA2;
    cpu_req = 1; cpu_addr = 12'h200;
    #1;
    n_total++;
    if ({ld_gnt, cpu_gnt} !== 2'b10 || mem_we !== 1'b1 || mem_wdata !== 8'hA2)
      $display("FAIL ld_prio got=%b we=%b wd=%h exp=10/1/a2", {ld_gnt, cpu_gnt}, mem_we, mem_wdata);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (ld_rvalid !== 1'b0) $display("FAIL ld_write_rvalid got=%b exp=0", ld_rvalid);
    else n_pass++;
    @(negedge clk);
    ld_req = 0;
    #1;
    n_total++;
    if ({ld_gnt, cpu_gnt} !== 2'b01 || mem_we !== 1'b0) $display("FAIL ld_cpu_after got=%b we=%b exp=01/0", {ld_gnt, cpu_gnt}, mem_we);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (cpu_rvalid !== 1'b1 || rdata !== 8'hA2) $display("FAIL ld_readback got=%b/%h exp=1/a2", cpu_rvalid, rdata);
    else n_pass++;
    @(negedge clk);
    set_idle();
    @(posedge clk); #1;
    n_total++;
    if (cpu_rvalid !== 1'b0) $display("FAIL rvalid_pulse got=%b exp=0", cpu_rvalid);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_lock_burst();
    do_reset();
    gpu_req = 1; gpu_addr = 12'h051;
    cpu_req = 1; cpu_we = 1; cpu_lock = 1;
    for (int k = 0; k < 3; k++) begin
      cpu_addr = 12'h300 + 12'(k); cpu_wdata = 8'h10 + 8'(k);
      if (k == 1) begin ld_req = 1; ld_we = 1; ld_addr = 12'h400; ld_wdata = 8'h55; end
      if (k == 2) cpu_lock = 0;
      #1;
      n_total++;
      if ({ld_gnt, cpu_gnt, gpu_gnt} !== 3'b010) $display("FAIL burst_gnt[%0d] got=%b exp=010", k, {ld_gnt, cpu_gnt, gpu_gnt});
      else n_pass++;
      @(negedge clk);
      if (k == 0) begin
        n_total++;
        if (dbg_owner !== 2'd2) $display("FAIL burst_owner got=%0d exp=2", dbg_owner);
        else n_pass++;
      end
    end
    cpu_req = 0;
    #1;
    n_total++;
    if ({ld_gnt, cpu_gnt, gpu_gnt} !== 3'b100) $display("FAIL burst_ld_next got=%b exp=100", {ld_gnt, cpu_gnt, gpu_gnt});
    else n_pass++;
    @(negedge clk);
    ld_req = 0;
    #1;
    n_total++;
    if ({ld_gnt, cpu_gnt, gpu_gnt} !== 3'b001) $display("FAIL burst_gpu_last got=%b exp=001", {ld_gnt, cpu_gnt, gpu_gnt});
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (gpu_rvalid !== 1'b1 || rdata !== 8'h33) $display("FAIL burst_gpu_read got=%b/%h exp=1/33", gpu_rvalid, rdata);
    else n_pass++;
    n_total++;
    if ({ram[12'h300], ram[12'h301], ram[12'h302], ram[12'h400]} !== 32'h10111255)
      $display("FAIL burst_ram got=%h exp=10111255", {ram[12'h300], ram[12'h301], ram[12'h302], ram[12'h400]});
    else n_pass++;
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_lock_release();
    do_reset();
    cpu_req = 1; cpu_lock = 1; cpu_addr = 12'h200; gpu_req = 1; gpu_addr = 12'h050;
    #1;
    n_total++;
    if ({cpu_gnt, gpu_gnt} !== 2'b10) $display("FAIL rel_first got=%b exp=10", {cpu_gnt, gpu_gnt});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (dbg_owner !== 2'd2) $display("FAIL rel_locked got=%0d exp=2", dbg_owner);
    else n_pass++;
    cpu_req = 0;
    #1;
    n_total++;
    if ({cpu_gnt, gpu_gnt} !== 2'b01) $display("FAIL rel_gpu_same got=%b exp=01", {cpu_gnt, gpu_gnt});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (dbg_owner !== 2'd0 || dbg_rr !== 1'b0) $display("FAIL rel_none got=%0d rr=%b exp=0/0", dbg_owner, dbg_rr);
    else n_pass++;
    cpu_req = 1;
    #1;
    n_total++;
    if ({cpu_gnt, gpu_gnt} !== 2'b10) $display("FAIL rel_rr_cpu got=%b exp=10", {cpu_gnt, gpu_gnt});
    else n_pass++;
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ld_req = 1; ld_we = 1;
    for (int k = 0; k < 3; k++) begin
      ld_addr = 12'h500 + 12'(k); ld_wdata = 8'hC0 + 8'(k);
      #1;
      n_total++;
      if (ld_gnt !== 1'b1 || mem_addr !== 12'h500 + 12'(k)) $display("FAIL b2b_gnt[%0d] got=%b/%h exp=1", k, ld_gnt, mem_addr);
      else n_pass++;
      @(negedge clk);
    end
    set_idle();
    gpu_req = 1; gpu_addr = 12'h502;
    @(posedge clk); #1;
    n_total++;
    if (gpu_rvalid !== 1'b1 || rdata !== 8'hC2) $display("FAIL b2b_readback got=%b/%h exp=1/c2", gpu_rvalid, rdata);
    else n_pass++;
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    gpu_req = 1; gpu_lock = 1; gpu_addr = 12'h050;
    #1;
    n_total++;
    if (gpu_gnt !== 1'b1) $display("FAIL mid_gnt got=%b exp=1", gpu_gnt);
    else n_pass++;
    @(posedge clk);
    reset = 1'b0;
    #1;
    set_idle();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) reset = 1'b1;
      n_total++;
      if (gpu_rvalid !== 1'b0 || dbg_owner !== 2'd0) $display("FAIL mid_rvalid[%0d] got=%b owner=%0d exp=0/0", k, gpu_rvalid, dbg_owner);
      else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h200] = 8'h11;
    ram[12'h050] = 8'h22;
    ram[12'h051] = 8'h33;
    mem_rdata = 8'h00;
    set_idle();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_loader_priority();
    test_lock_burst();
    test_lock_release();
    test_back_to_back();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
